// File: rtl/sort_peak_serializer.sv
// Captures a sorted frame from the bitonic sorter, streams its TOP_K largest entries over valid/ready,
// then pulses sort_restart. Optional threshold gating is enabled by defining PEAK_THRESHOLD_EN.
module sort_peak_serializer #(
  parameter int SIZE           = 16,
  parameter int TOP_K          = 4,
  parameter int LARGEST_AT_TOP = 1,
  parameter int NETWORK_WIDTH  = 16,
  parameter int INDEX_WIDTH    = $clog2(SIZE),
  localparam int RW            = (TOP_K > 1) ? $clog2(TOP_K) : 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                sort_done,
  input  logic [SIZE-1:0][NETWORK_WIDTH-1:0]  sort_data_in,
  input  logic [SIZE-1:0][INDEX_WIDTH-1:0]    sort_index_in,
  output logic                                sort_restart,
  output logic                                peak_valid,
  input  logic                                peak_ready,
  output logic [NETWORK_WIDTH-1:0]            peak_data,
  output logic [INDEX_WIDTH-1:0]              peak_index,
  output logic [RW-1:0]                       peak_rank,
  output logic                                peak_last,
`ifdef PEAK_THRESHOLD_EN
  input  logic [NETWORK_WIDTH-1:0]            peak_threshold,
  output logic                                frame_empty,
`endif
  output logic [15:0]                         frame_count
);

  localparam int LW = (SIZE > 1) ? $clog2(SIZE) : 1;

  typedef enum logic [1:0] {WAIT_DONE, EMIT, RESTART} state_t;

  state_t                               state_q, state_d;
  logic                                 armed_q, armed_d;
  logic [SIZE-1:0][NETWORK_WIDTH-1:0]   data_buf_q, data_buf_d;
  logic [SIZE-1:0][INDEX_WIDTH-1:0]     index_buf_q, index_buf_d;
  logic [RW-1:0]                        rank_q, rank_d;
  logic [15:0]                          count_q, count_d;
  logic                                 valid_q, valid_d;
  logic [NETWORK_WIDTH-1:0]             data_q, data_d;
  logic [INDEX_WIDTH-1:0]               index_q, index_d;
  logic                                 last_q, last_d;
  logic                                 restart_q, restart_d;
`ifdef PEAK_THRESHOLD_EN
  logic [NETWORK_WIDTH-1:0]             thr_q, thr_d;
  logic                                 empty_q, empty_d;
  logic [NETWORK_WIDTH-1:0]             src_thr;
`endif

  logic                                 present;
  int                                   next_rank;
  logic [SIZE-1:0][NETWORK_WIDTH-1:0]   src_data;
  logic [SIZE-1:0][INDEX_WIDTH-1:0]     src_index;

  // Rank 0 is always the largest entry, wherever the sorter placed it.
  function automatic logic [LW-1:0] lane_of(input int rank);
    int lane;
    lane = (LARGEST_AT_TOP != 0) ? (SIZE - 1 - rank) : rank;
    if (lane < 0) lane = 0;
    if (lane > SIZE - 1) lane = SIZE - 1;
    return LW'(lane);
  endfunction

  always_comb begin
    state_d     = state_q;
    armed_d     = armed_q;
    data_buf_d  = data_buf_q;
    index_buf_d = index_buf_q;
    rank_d      = rank_q;
    count_d     = count_q;
    valid_d     = valid_q;
    data_d      = data_q;
    index_d     = index_q;
    last_d      = last_q;
    restart_d   = 1'b0;
    present     = 1'b0;
    next_rank   = 0;
    src_data    = data_buf_q;
    src_index   = index_buf_q;
`ifdef PEAK_THRESHOLD_EN
    thr_d       = thr_q;
    empty_d     = 1'b0;
    src_thr     = thr_q;
`endif

    case (state_q)
      WAIT_DONE: begin
        if (!sort_done) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          armed_d     = 1'b0;
          data_buf_d  = sort_data_in;
          index_buf_d = sort_index_in;
          rank_d      = '0;
          src_data    = sort_data_in;
          src_index   = sort_index_in;
`ifdef PEAK_THRESHOLD_EN
          thr_d   = peak_threshold;
          src_thr = peak_threshold;
          if (sort_data_in[lane_of(0)] > peak_threshold) begin
            present = 1'b1;
          end else begin
            empty_d   = 1'b1;
            count_d   = count_q + 16'd1;
            restart_d = 1'b1;
            state_d   = RESTART;
          end
`else
          present = 1'b1;
`endif
        end
      end
      EMIT: begin
        if (valid_q && peak_ready) begin
          if (last_q) begin
            valid_d   = 1'b0;
            last_d    = 1'b0;
            restart_d = 1'b1;
            count_d   = count_q + 16'd1;
            state_d   = RESTART;
          end else begin
            present   = 1'b1;
            next_rank = int'(rank_q) + 1;
          end
        end
      end
      RESTART: state_d = WAIT_DONE;
      default: state_d = WAIT_DONE;
    endcase

    // Payload is registered, so the lookahead for peak_last is made from the source vector here.
    if (present) begin
      state_d = EMIT;
      valid_d = 1'b1;
      rank_d  = RW'(next_rank);
      data_d  = src_data[lane_of(next_rank)];
      index_d = src_index[lane_of(next_rank)];
      last_d  = (next_rank >= TOP_K - 1);
`ifdef PEAK_THRESHOLD_EN
      if (!last_d && !(src_data[lane_of(next_rank + 1)] > src_thr)) last_d = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= WAIT_DONE;
      armed_q     <= 1'b0;
      data_buf_q  <= '0;
      index_buf_q <= '0;
      rank_q      <= '0;
      count_q     <= '0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      index_q     <= '0;
      last_q      <= 1'b0;
      restart_q   <= 1'b0;
`ifdef PEAK_THRESHOLD_EN
      thr_q       <= '0;
      empty_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      armed_q     <= armed_d;
      data_buf_q  <= data_buf_d;
      index_buf_q <= index_buf_d;
      rank_q      <= rank_d;
      count_q     <= count_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      index_q     <= index_d;
      last_q      <= last_d;
      restart_q   <= restart_d;
`ifdef PEAK_THRESHOLD_EN
      thr_q       <= thr_d;
      empty_q     <= empty_d;
`endif
    end
  end

  assign sort_restart = restart_q;
  assign peak_valid   = valid_q;
  assign peak_data    = data_q;
  assign peak_index   = index_q;
  assign peak_rank    = rank_q;
  assign peak_last    = last_q;
  assign frame_count  = count_q;
`ifdef PEAK_THRESHOLD_EN
  assign frame_empty  = empty_q;
`endif

endmodule

// File: tb/tb_sort_peak_serializer.sv
// Self-checking bench for sort_peak_serializer: directed frames plus randomized frames checked
// against a lane-walk reference queue. Threshold cases run when PEAK_THRESHOLD_EN is defined.
module tb_sort_peak_serializer;
  localparam int SIZE   = 16;
  localparam int TOP_K  = 4;
  localparam int NW     = 16;
  localparam int IW     = 4;
  localparam int RW     = 2;
  localparam int SIZE_B = 4;
`ifdef PEAK_THRESHOLD_EN
  localparam bit THR_EN = 1'b1;
`else
  localparam bit THR_EN = 1'b0;
`endif

  typedef struct {
    logic [NW-1:0] data;
    logic [IW-1:0] index;
    int            rank;
    logic          last;
  } beat_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  logic                      sort_done_a;
  logic [SIZE-1:0][NW-1:0]   sort_data_a;
  logic [SIZE-1:0][IW-1:0]   sort_index_a;
  logic                      sort_restart_a;
  logic                      peak_valid_a;
  logic                      peak_ready_a;
  logic [NW-1:0]             peak_data_a;
  logic [IW-1:0]             peak_index_a;
  logic [RW-1:0]             peak_rank_a;
  logic                      peak_last_a;
  logic [15:0]               frame_count_a;

  logic                      sort_done_b;
  logic [SIZE_B-1:0][NW-1:0] sort_data_b;
  logic [SIZE_B-1:0][IW-1:0] sort_index_b;
  logic                      sort_restart_b;
  logic                      peak_valid_b;
  logic                      peak_ready_b;
  logic [NW-1:0]             peak_data_b;
  logic [IW-1:0]             peak_index_b;
  logic [0:0]                peak_rank_b;
  logic                      peak_last_b;
  logic [15:0]               frame_count_b;

`ifdef PEAK_THRESHOLD_EN
  logic [NW-1:0] thr_a;
  logic [NW-1:0] thr_b;
  logic          frame_empty_a;
  logic          frame_empty_b;
`endif

  int    total = 0;
  int    bad   = 0;
  int    model_count_a = 0;
  beat_t exp_q[$];

  always #5 clk = ~clk;

  sort_peak_serializer #(
    .SIZE(SIZE), .TOP_K(TOP_K), .LARGEST_AT_TOP(1), .NETWORK_WIDTH(NW), .INDEX_WIDTH(IW)
  ) dut_a (
    .clk(clk), .reset(reset), .sort_done(sort_done_a),
    .sort_data_in(sort_data_a), .sort_index_in(sort_index_a),
    .sort_restart(sort_restart_a), .peak_valid(peak_valid_a), .peak_ready(peak_ready_a),
    .peak_data(peak_data_a), .peak_index(peak_index_a), .peak_rank(peak_rank_a),
    .peak_last(peak_last_a),
`ifdef PEAK_THRESHOLD_EN
    .peak_threshold(thr_a), .frame_empty(frame_empty_a),
`endif
    .frame_count(frame_count_a)
  );

  sort_peak_serializer #(
    .SIZE(SIZE_B), .TOP_K(1), .LARGEST_AT_TOP(0), .NETWORK_WIDTH(NW), .INDEX_WIDTH(IW)
  ) dut_b (
    .clk(clk), .reset(reset), .sort_done(sort_done_b),
    .sort_data_in(sort_data_b), .sort_index_in(sort_index_b),
    .sort_restart(sort_restart_b), .peak_valid(peak_valid_b), .peak_ready(peak_ready_b),
    .peak_data(peak_data_b), .peak_index(peak_index_b), .peak_rank(peak_rank_b),
    .peak_last(peak_last_b),
`ifdef PEAK_THRESHOLD_EN
    .peak_threshold(thr_b), .frame_empty(frame_empty_b),
`endif
    .frame_count(frame_count_b)
  );

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: walk from the largest lane down, keep qualifying entries up to TOP_K.
  task automatic build_expected(input logic [NW-1:0] thr);
    beat_t b;
    int    n;
    exp_q.delete();
    n = 0;
    for (int r = 0; r < TOP_K; r++) begin
      if (THR_EN && !(sort_data_a[4'(SIZE - 1 - r)] > thr)) break;
      n++;
    end
    for (int r = 0; r < n; r++) begin
      b.data  = sort_data_a[4'(SIZE - 1 - r)];
      b.index = sort_index_a[4'(SIZE - 1 - r)];
      b.rank  = r;
      b.last  = (r == n - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic apply_stimulus();
    for (int i = 0; i < SIZE - 4; i++) begin
      sort_data_a[4'(i)]  = NW'(i + 1);
      sort_index_a[4'(i)] = IW'(i);
    end
    sort_data_a[4'(15)] = 16'd90; sort_index_a[4'(15)] = 4'd3;
    sort_data_a[4'(14)] = 16'd80; sort_index_a[4'(14)] = 4'd9;
    sort_data_a[4'(13)] = 16'd70; sort_index_a[4'(13)] = 4'd1;
    sort_data_a[4'(12)] = 16'd60; sort_index_a[4'(12)] = 4'd14;
  endtask

  task automatic set_random_frame();
    logic [NW-1:0] vals[$];
    for (int i = 0; i < SIZE; i++) vals.push_back(NW'($urandom_range(0, 500)));
    vals.sort();
    for (int i = 0; i < SIZE; i++) begin
      sort_data_a[4'(i)]  = vals[i];
      sort_index_a[4'(i)] = IW'($urandom_range(0, 15));
    end
  endtask

  // ready_mode: 0 = always ready, 1 = toggle starting low, 2 = random.
  task automatic run_frame_a(input int ready_mode, input logic [NW-1:0] thr,
                             input bit drop_done, input int abort_after);
    int    pops;
    bit    finished;
    bit    was_empty;
    bit    tog;
    beat_t f;
    pops = 0; finished = 1'b0; tog = 1'b0;
    build_expected(thr);
    was_empty = (exp_q.size() == 0);
`ifdef PEAK_THRESHOLD_EN
    thr_a = thr;
`endif
    sort_done_a = 1'b1;
    for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
      step();
      if (abort_after >= 0 && pops == abort_after) begin
        reset = 1'b1; sort_done_a = 1'b0; peak_ready_a = 1'b0;
        step();
        model_count_a = 0;
        check_output("abort_valid", 32'(peak_valid_a), 32'd0);
        check_output("abort_data", 32'(peak_data_a), 32'd0);
        check_output("abort_index", 32'(peak_index_a), 32'd0);
        check_output("abort_rank", 32'(peak_rank_a), 32'd0);
        check_output("abort_last", 32'(peak_last_a), 32'd0);
        check_output("abort_restart", 32'(sort_restart_a), 32'd0);
        check_output("abort_count", 32'(frame_count_a), 32'(model_count_a));
        reset = 1'b0;
        step();
        exp_q.delete();
        return;
      end
      if (exp_q.size() > 0) begin
        f = exp_q[0];
        check_output("beat_valid", 32'(peak_valid_a), 32'd1);
        check_output("beat_data", 32'(peak_data_a), 32'(f.data));
        check_output("beat_index", 32'(peak_index_a), 32'(f.index));
        check_output("beat_rank", 32'(peak_rank_a), 32'(f.rank));
        check_output("beat_last", 32'(peak_last_a), 32'(f.last));
        check_output("beat_no_restart", 32'(sort_restart_a), 32'd0);
        case (ready_mode)
          0:       peak_ready_a = 1'b1;
          1:       begin peak_ready_a = tog; tog = ~tog; end
          default: peak_ready_a = 1'($urandom_range(0, 1));
        endcase
        if (peak_ready_a) begin
          void'(exp_q.pop_front());
          pops++;
        end
      end else begin
        check_output("restart_pulse", 32'(sort_restart_a), 32'd1);
        check_output("restart_valid", 32'(peak_valid_a), 32'd0);
`ifdef PEAK_THRESHOLD_EN
        check_output("frame_empty", 32'(frame_empty_a), 32'(was_empty));
`endif
        model_count_a = (model_count_a + 1) & 32'hFFFF;
        finished = 1'b1;
      end
    end
    if (!finished) check_output("frame_timeout", 32'd0, 32'd1);
    check_output("frame_count", 32'(frame_count_a), 32'(model_count_a));
    if (drop_done) sort_done_a = 1'b0;
    step();
    check_output("restart_one_cycle", 32'(sort_restart_a), 32'd0);
    check_output("idle_valid", 32'(peak_valid_a), 32'd0);
    if (drop_done) step();
  endtask

  initial begin
    sort_done_a = 1'b0; peak_ready_a = 1'b0; sort_data_a = '0; sort_index_a = '0;
    sort_done_b = 1'b0; peak_ready_b = 1'b1; sort_data_b = '0; sort_index_b = '0;
`ifdef PEAK_THRESHOLD_EN
    thr_a = '0; thr_b = '0;
`endif
    reset = 1'b1;
    step();
    step();
    check_output("reset_valid", 32'(peak_valid_a), 32'd0);
    check_output("reset_restart", 32'(sort_restart_a), 32'd0);
    check_output("reset_last", 32'(peak_last_a), 32'd0);
    check_output("reset_data", 32'(peak_data_a), 32'd0);
    check_output("reset_count", 32'(frame_count_a), 32'd0);
    check_output("reset_valid_b", 32'(peak_valid_b), 32'd0);
    reset = 1'b0;
    step();

    // Reset after two accepted beats, then the directed frame with full and half-rate ready.
    apply_stimulus();
    run_frame_a(0, 16'd0, 1'b1, 2);
    run_frame_a(0, 16'd0, 1'b1, -1);
    run_frame_a(1, 16'd0, 1'b1, -1);

    // A done that never drops must not start a second frame.
    run_frame_a(0, 16'd0, 1'b0, -1);
    for (int i = 0; i < 6; i++) begin
      step();
      check_output("held_done_valid", 32'(peak_valid_a), 32'd0);
      check_output("held_done_restart", 32'(sort_restart_a), 32'd0);
    end
    check_output("held_done_count", 32'(frame_count_a), 32'(model_count_a));
    sort_done_a = 1'b0;
    step();
    run_frame_a(0, 16'd0, 1'b1, -1);

`ifdef PEAK_THRESHOLD_EN
    run_frame_a(0, 16'd75, 1'b1, -1);
    run_frame_a(2, 16'd95, 1'b1, -1);
`endif

    for (int fr = 0; fr < 6; fr++) begin
      set_random_frame();
      run_frame_a(2, THR_EN ? NW'($urandom_range(0, 400)) : 16'd0, 1'b1, -1);
    end

    // Smallest-at-top ordering with a single peak per frame.
    sort_data_b  = {16'h0010, 16'h0020, 16'h0040, 16'h00FF};
    sort_index_b = {4'd0, 4'd2, 4'd7, 4'd5};
    sort_done_b  = 1'b1;
    step();
    check_output("b_valid", 32'(peak_valid_b), 32'd1);
    check_output("b_data", 32'(peak_data_b), 32'h00FF);
    check_output("b_index", 32'(peak_index_b), 32'd5);
    check_output("b_rank", 32'(peak_rank_b), 32'd0);
    check_output("b_last", 32'(peak_last_b), 32'd1);
    step();
    check_output("b_restart", 32'(sort_restart_b), 32'd1);
    check_output("b_valid_after", 32'(peak_valid_b), 32'd0);
    check_output("b_count", 32'(frame_count_b), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
